// File: rtl/spi_vec_bank_if.sv
// SPI slave pins for spi_vec_bank: the master drives clock/select/data, the slave drives readback.
interface spi_vec_bank_if;
  logic i_sclk;
  logic i_ss_n;
  logic i_mosi;
  logic o_miso;

  modport master (output i_sclk, output i_ss_n, output i_mosi, input o_miso);
  modport slave  (input i_sclk, input i_ss_n, input i_mosi, output o_miso);
endinterface

// File: rtl/spi_vec_bank.sv
// SPI mode-0 slave writing a shadow bank of NVEC vectors, committed to live registers on load_if_ready.
// Define SPI_READBACK_EN to let RD=1 headers shift live vectors out on o_miso.
module spi_vec_bank #(
  parameter int NVEC = 6,
  parameter int VW   = 15,
  parameter logic [NVEC*VW-1:0] INIT = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  spi_vec_bank_if.slave        spi,
  input  logic [NVEC-1:0]      i_dec,
  input  logic                 load_if_ready,
  output logic [NVEC*VW-1:0]   o_vec,
  output logic                 o_committed,
  output logic                 o_err
);
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAY, S_DONE, S_IGN} state_t;

  localparam logic [VW-1:0] ONE      = VW'(1);
  localparam logic [4:0]    LAST_BIT = 5'(VW - 1);

  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [1:0] ss_sync_q, ss_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic       sclk_rise, ss_b, mosi_b;

  state_t              state_q;
  logic [4:0]          cnt_q;
  logic [6:0]          hdr_q;
  logic [VW-1:0]       dsh_q;
  logic [3:0]          vidx_q;
  logic [2:0]          rem_q;
  logic                rd_q;
  logic                err_q;
  logic [NVEC-1:0]     wmask_q;
  logic [NVEC*VW-1:0]  stage_q;

  logic [NVEC*VW-1:0]  live_q, live_d;
  logic [NVEC*VW-1:0]  shadow_q, shadow_d;
  logic [NVEC-1:0]     dirty_q, dirty_d;
  logic                committed_q, committed_d;

  logic [7:0]          hdr_byte;
  logic [3:0]          hdr_start;
  logic [2:0]          hdr_nm1;
  logic                hdr_bad;
  logic [VW-1:0]       pay_word;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], spi.i_sclk};
    ss_sync_d   = {ss_sync_q[0], spi.i_ss_n};
    mosi_sync_d = {mosi_sync_q[0], spi.i_mosi};
  end

  assign sclk_rise = (sclk_sync_q[2:1] == 2'b01);
  assign ss_b      = ss_sync_q[1];
  assign mosi_b    = mosi_sync_q[1];

  assign hdr_byte  = {hdr_q, mosi_b};
  assign hdr_start = hdr_byte[6:3];
  assign hdr_nm1   = hdr_byte[2:0];
  assign pay_word  = {dsh_q[VW-2:0], mosi_b};

  always_comb begin
    hdr_bad = (int'(hdr_start) + int'(hdr_nm1) + 1) > NVEC;
`ifndef SPI_READBACK_EN
    if (hdr_byte[7]) hdr_bad = 1'b1;
`endif
  end

`ifdef SPI_READBACK_EN
  logic          sclk_fall;
  logic          miso_q;
  logic [VW-1:0] rsh_q;
  logic          pend_q;

  assign sclk_fall = (sclk_sync_q[2:1] == 2'b10);
  assign spi.o_miso = miso_q;

  function automatic logic [VW-1:0] pick(input logic [NVEC*VW-1:0] bank, input logic [3:0] idx);
    logic [VW-1:0] r;
    r = '0;
    for (int k = 0; k < NVEC; k++)
      if (idx == 4'(k)) r = bank[k*VW +: VW];
    return r;
  endfunction
`else
  assign spi.o_miso = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= 3'b000;
      ss_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
    end
  end

  // Frame FSM: header decode, payload staging, optional readback shifter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hdr_q   <= '0;
      dsh_q   <= '0;
      vidx_q  <= '0;
      rem_q   <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      wmask_q <= '0;
`ifdef SPI_READBACK_EN
      miso_q  <= 1'b0;
      rsh_q   <= '0;
      pend_q  <= 1'b0;
`endif
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!ss_b) state_q <= S_HDR;
        end
        S_DONE: begin
          cnt_q   <= '0;
          wmask_q <= '0;
          state_q <= ss_b ? S_IDLE : S_HDR;
        end
        default: begin
          if (ss_b) begin
            // Deselect abandons whatever was staged; shadow only moves at DONE.
            state_q <= S_HDR;
            cnt_q   <= '0;
            wmask_q <= '0;
`ifdef SPI_READBACK_EN
            pend_q  <= 1'b0;
`endif
          end else if (state_q == S_HDR) begin
            if (sclk_rise) begin
              hdr_q <= hdr_byte[6:0];
              if (cnt_q == 5'd7) begin
                cnt_q <= '0;
                if (hdr_bad) begin
                  err_q   <= 1'b1;
                  state_q <= S_IGN;
                end else begin
                  state_q <= S_PAY;
                  rd_q    <= hdr_byte[7];
                  vidx_q  <= hdr_start;
                  rem_q   <= hdr_nm1;
                  wmask_q <= '0;
`ifdef SPI_READBACK_EN
                  if (hdr_byte[7]) begin
                    miso_q <= pick(live_q, hdr_start) >> (VW - 1) != '0;
                    rsh_q  <= pick(live_q, hdr_start) << 1;
                    pend_q <= 1'b0;
                  end
`endif
                end
              end else begin
                cnt_q <= cnt_q + 5'd1;
              end
            end
          end else if (state_q == S_PAY) begin
            if (sclk_rise) begin
              dsh_q <= pay_word;
`ifdef SPI_READBACK_EN
              pend_q <= 1'b1;
`endif
              if (cnt_q == LAST_BIT) begin
                cnt_q <= '0;
                if (!rd_q) begin
                  for (int k = 0; k < NVEC; k++) begin
                    if (vidx_q == 4'(k)) begin
                      stage_q[k*VW +: VW] <= pay_word;
                      wmask_q[k]          <= 1'b1;
                    end
                  end
                end
                if (rem_q == 3'd0) begin
                  state_q <= S_DONE;
                end else begin
                  vidx_q <= vidx_q + 4'd1;
                  rem_q  <= rem_q - 3'd1;
`ifdef SPI_READBACK_EN
                  rsh_q  <= pick(live_q, vidx_q + 4'd1);
`endif
                end
              end else begin
                cnt_q <= cnt_q + 5'd1;
              end
            end
`ifdef SPI_READBACK_EN
            else if (sclk_fall && pend_q && rd_q) begin
              miso_q <= rsh_q[VW-1];
              rsh_q  <= rsh_q << 1;
              pend_q <= 1'b0;
            end
`endif
          end
        end
      endcase
    end
  end

  // Bank update: commit or decrement on the strobe, then fold in this frame's DONE
  always_comb begin
    live_d      = live_q;
    shadow_d    = shadow_q;
    dirty_d     = dirty_q;
    committed_d = 1'b0;
    if (load_if_ready) begin
      if (i_dec == '0) begin
        for (int k = 0; k < NVEC; k++)
          if (dirty_q[k]) live_d[k*VW +: VW] = shadow_q[k*VW +: VW];
        committed_d = |dirty_q;
      end else begin
        for (int k = 0; k < NVEC; k++)
          if (i_dec[k]) live_d[k*VW +: VW] = live_q[k*VW +: VW] - ONE;
      end
      dirty_d = '0;
    end
    if (state_q == S_DONE) begin
      for (int k = 0; k < NVEC; k++)
        if (wmask_q[k]) shadow_d[k*VW +: VW] = stage_q[k*VW +: VW];
      dirty_d = dirty_d | wmask_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      live_q      <= INIT;
      shadow_q    <= INIT;
      dirty_q     <= '0;
      committed_q <= 1'b0;
    end else begin
      live_q      <= live_d;
      shadow_q    <= shadow_d;
      dirty_q     <= dirty_d;
      committed_q <= committed_d;
    end
  end

  assign o_vec       = live_q;
  assign o_committed = committed_q;
  assign o_err       = err_q;
endmodule

// File: tb/tb_spi_vec_bank.sv
// Directed bench for spi_vec_bank: SPI frames, commit/decrement strobes, abort, error and readback cases.
module tb_spi_vec_bank;
  localparam int NVEC = 6;
  localparam int VW   = 15;
  localparam int HALF = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NVEC-1:0]   i_dec = '0;
  logic              load_if_ready = 1'b0;
  logic [NVEC*VW-1:0] o_vec;
  logic              o_committed;
  logic              o_err;

  int nvec = 0;
  int nerr = 0;
  int err_cnt = 0;
  int com_cnt = 0;
  int e0, c0;
  logic [31:0] g;

  spi_vec_bank_if spi ();

  spi_vec_bank #(.NVEC(NVEC), .VW(VW)) dut (
    .clk           (clk),
    .reset         (reset),
    .spi           (spi),
    .i_dec         (i_dec),
    .load_if_ready (load_if_ready),
    .o_vec         (o_vec),
    .o_committed   (o_committed),
    .o_err         (o_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_err) err_cnt++;
    if (o_committed) com_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] vec(input int k);
    return 32'(o_vec[k*VW +: VW]);
  endfunction

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI bit; miso is captured just before the rising edge. With strobe set,
  // load_if_ready is timed to land in the same clk as the resulting DONE state.
  task automatic spi_bit(input logic b, input logic strobe, output logic m);
    spi.i_mosi = b;
    wait_n(HALF);
    m = spi.o_miso;
    spi.i_sclk = 1'b1;
    if (strobe) begin
      wait_n(3);
      load_if_ready = 1'b1;
      wait_n(1);
      load_if_ready = 1'b0;
      wait_n(HALF - 4);
    end else begin
      wait_n(HALF);
    end
    spi.i_sclk = 1'b0;
  endtask

  task automatic spi_word(input logic [31:0] w, input int nb, input logic strobe_last, output logic [31:0] got);
    logic m;
    got = '0;
    for (int i = nb - 1; i >= 0; i--) begin
      spi_bit(w[i], strobe_last && (i == 0), m);
      got = {got[30:0], m};
    end
  endtask

  task automatic ss_low();
    spi.i_ss_n = 1'b0;
    wait_n(HALF);
  endtask

  task automatic ss_high();
    wait_n(HALF);
    spi.i_ss_n = 1'b1;
    wait_n(HALF);
  endtask

  task automatic write1(input logic [31:0] hdr, input logic [31:0] val, input logic strobe_last);
    logic [31:0] d;
    ss_low();
    spi_word(hdr, 8, 1'b0, d);
    spi_word(val, VW, strobe_last, d);
    ss_high();
  endtask

  task automatic strobe(input logic [NVEC-1:0] dec);
    load_if_ready = 1'b1;
    i_dec = dec;
    wait_n(1);
    load_if_ready = 1'b0;
    i_dec = '0;
    wait_n(2);
  endtask

  initial begin
    spi.i_sclk = 1'b0;
    spi.i_ss_n = 1'b1;
    spi.i_mosi = 1'b0;
    wait_n(4);
    chk("rst_vec", 32'(o_vec == '0), 32'd1);
    chk("rst_miso", 32'(spi.o_miso), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_com", 32'(o_committed), 32'd0);
    reset = 1'b0;
    wait_n(4);

    // Six-vector write 1..6, visible only after the strobe
    e0 = err_cnt; c0 = com_cnt;
    ss_low();
    spi_word(32'h05, 8, 1'b0, g);
    for (int k = 1; k <= 6; k++) spi_word(32'(k), VW, 1'b0, g);
    ss_high();
    chk("pre_strobe_v0", vec(0), 32'd0);
    strobe('0);
    for (int k = 0; k < 6; k++) chk($sformatf("wr6_v%0d", k), vec(k), 32'(k + 1));
    chk("wr6_com", 32'(com_cnt - c0), 32'd1);
    chk("wr6_err", 32'(err_cnt - e0), 32'd0);
    c0 = com_cnt;
    strobe('0);
    chk("clean_strobe_com", 32'(com_cnt - c0), 32'd0);

    // start 5 + N 2 overflows the bank: one error pulse, nothing staged
    e0 = err_cnt; c0 = com_cnt;
    ss_low();
    spi_word(32'h29, 8, 1'b0, g);
    spi_word(32'h7FFF, VW, 1'b0, g);
    spi_word(32'h7FFF, VW, 1'b0, g);
    ss_high();
    chk("bad_hdr_err", 32'(err_cnt - e0), 32'd1);
    strobe('0);
    chk("bad_hdr_com", 32'(com_cnt - c0), 32'd0);
    chk("bad_hdr_v5", vec(5), 32'd6);

    // start 5 + N 1 exactly fills the bank and is accepted
    e0 = err_cnt; c0 = com_cnt;
    write1(32'h28, 32'h2ABC, 1'b0);
    chk("edge_hdr_err", 32'(err_cnt - e0), 32'd0);
    strobe('0);
    chk("edge_hdr_v5", vec(5), 32'h2ABC);
    chk("edge_hdr_com", 32'(com_cnt - c0), 32'd1);

    // Decrement wraps live[0]; pending write to vector 2 is dropped
    write1(32'h00, 32'h0000, 1'b0);
    strobe('0);
    chk("v0_zero", vec(0), 32'd0);
    write1(32'h10, 32'h0055, 1'b0);
    c0 = com_cnt;
    strobe(6'b000001);
    chk("dec_wrap_v0", vec(0), 32'h7FFF);
    chk("dec_v2_keep", vec(2), 32'd3);
    chk("dec_com", 32'(com_cnt - c0), 32'd0);
    strobe('0);
    chk("dec_dirty_clr_v2", vec(2), 32'd3);
    chk("dec_dirty_clr_com", 32'(com_cnt - c0), 32'd0);

    // DONE and strobe in the same clk: the write waits for the next strobe
    c0 = com_cnt;
    write1(32'h08, 32'h0009, 1'b1);
    chk("coinc_v1_hold", vec(1), 32'd2);
    chk("coinc_com_none", 32'(com_cnt - c0), 32'd0);
    strobe('0);
    chk("coinc_v1_next", vec(1), 32'd9);
    chk("coinc_com_next", 32'(com_cnt - c0), 32'd1);

    // i_dec without the strobe does nothing
    i_dec = '1;
    wait_n(5);
    i_dec = '0;
    wait_n(2);
    chk("dec_no_strobe_v0", vec(0), 32'h7FFF);
    chk("dec_no_strobe_v1", vec(1), 32'd9);

    // Abort after 20 of 23 bits
    c0 = com_cnt;
    ss_low();
    spi_word(32'h18, 8, 1'b0, g);
    spi_word(32'h0ABC, 12, 1'b0, g);
    ss_high();
    strobe('0);
    chk("abort_com", 32'(com_cnt - c0), 32'd0);
    chk("abort_v3", vec(3), 32'd4);
    write1(32'h18, 32'h1234, 1'b0);
    strobe('0);
    chk("after_abort_v3", vec(3), 32'h1234);

    // Read header on vector 3
    e0 = err_cnt; c0 = com_cnt;
    ss_low();
    spi_word(32'h98, 8, 1'b0, g);
    spi_word(32'h0000, VW, 1'b0, g);
    ss_high();
    strobe('0);
`ifdef SPI_READBACK_EN
    chk("rd_bits", g & 32'h7FFF, 32'h1234);
    chk("rd_err", 32'(err_cnt - e0), 32'd0);
`else
    chk("rd_bits_tied", g & 32'h7FFF, 32'h0000);
    chk("rd_err", 32'(err_cnt - e0), 32'd1);
`endif
    chk("rd_com", 32'(com_cnt - c0), 32'd0);
    chk("rd_v3", vec(3), 32'h1234);

    // Multi-bit decrement
    strobe(6'b001010);
    chk("dec2_v1", vec(1), 32'd8);
    chk("dec2_v3", vec(3), 32'h1233);
    chk("dec2_v4", vec(4), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish, required finish before 2ms");
    $fatal(1);
  end
endmodule
